// File: rtl/comp_serial_ctrl_pkg.sv
// Shared types and helpers for the bit-serial magnitude comparator.
// FSM state encoding and the operand-width legality check.
package comp_serial_ctrl_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic bit width_legal(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/comp_serial_ctrl_if.sv
// Request/result bundle of the serial comparator: start + operands in,
// busy/done + eq/gt/lt out.
interface comp_serial_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;

  modport master (
    output start, a_in, b_in,
    input  busy, done, eq, gt, lt
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, eq, gt, lt
  );
endinterface

// File: rtl/comp_serial_ctrl_comp1b.sv
// One-bit equality cell shared by the serial comparator: c=1 when a==b.
module comp1b (
  input  logic i_a,
  input  logic i_b,
  output logic o_c
);
  assign o_c = ~(i_a ^ i_b);
endmodule

// File: rtl/comp_serial_ctrl.sv
// Bit-serial magnitude comparator: walks both operands MSB first through comp1b.
// Optional EARLY_EXIT_EN ends the scan on the first differing bit.
module comp_serial_ctrl
  import comp_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  comp_serial_ctrl_if.slave cmp
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int MSB   = WIDTH - 1;

  generate
    if (!width_legal(WIDTH)) begin : g_bad_width
      $error("comp_serial_ctrl: WIDTH must be within 2..32");
    end
  endgenerate

  state_e           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_flag;
  logic             r_gt_r;
  logic             r_lt_r;
  logic             r_busy;
  logic             r_done;
  logic             r_eq;
  logic             r_gt;
  logic             r_lt;

  logic w_c;
  logic w_mis;
  logic w_flag_nx;
  logic w_gt_nx;
  logic w_lt_nx;
  logic w_last;

  comp1b u_comp1b (
    .i_a (r_sa[MSB]),
    .i_b (r_sb[MSB]),
    .o_c (w_c)
  );

  // Only the first differing bit decides the ordering; later bits are ignored.
  assign w_mis     = ~w_c & ~r_flag;
  assign w_flag_nx = r_flag | w_mis;
  assign w_gt_nx   = w_mis ? r_sa[MSB] : r_gt_r;
  assign w_lt_nx   = w_mis ? r_sb[MSB] : r_lt_r;

`ifdef EARLY_EXIT_EN
  assign w_last = (r_cnt == '0) | w_mis;
`else
  assign w_last = (r_cnt == '0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_cnt   <= '0;
      r_flag  <= 1'b0;
      r_gt_r  <= 1'b0;
      r_lt_r  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (cmp.start) begin
            r_sa    <= cmp.a_in;
            r_sb    <= cmp.b_in;
            r_cnt   <= CNT_W'(WIDTH - 1);
            r_flag  <= 1'b0;
            r_gt_r  <= 1'b0;
            r_lt_r  <= 1'b0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_flag <= w_flag_nx;
          r_gt_r <= w_gt_nx;
          r_lt_r <= w_lt_nx;
          r_sa   <= {r_sa[WIDTH-2:0], 1'b0};
          r_sb   <= {r_sb[WIDTH-2:0], 1'b0};
          r_cnt  <= r_cnt - CNT_W'(1);
          // Results are published from the same next-state values the flag takes.
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_eq    <= ~w_flag_nx;
            r_gt    <= w_gt_nx;
            r_lt    <= w_lt_nx;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmp.busy = r_busy;
  assign cmp.done = r_done;
  assign cmp.eq   = r_eq;
  assign cmp.gt   = r_gt;
  assign cmp.lt   = r_lt;

endmodule
